// File: rtl/ul8_bus_pkg.sv
// Shared definitions for the 8-bit register-bus transfer controller.
// Optional feature macro: UL8_BUS_IMM_EN (adds an immediate source index).
package ul8_bus_pkg;

   localparam int BUS_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_CAPTURE,
      ST_RELEASE,
      ST_ERROR
   } bus_state_e;

   // Index width: enough for every register, plus one extra code point for
   // the immediate source when that feature is built in.
   function automatic int sel_width(input int num_regs);
`ifdef UL8_BUS_IMM_EN
      return $clog2(num_regs) + 1;
`else
      return $clog2(num_regs);
`endif
   endfunction

endpackage

// File: rtl/bus_sel_decoder.sv
// Index + enable to one-hot strobe decoder for the register bus.
// Indices outside 0..NUM_REGS-1 decode to all-zero.
module bus_sel_decoder #(
   parameter int NUM_REGS = 4,
   parameter int SELW     = 2
) (
   input  logic [SELW-1:0]     idx,
   input  logic                en,
   output logic [NUM_REGS-1:0] onehot
);

   // One bit per register, at most one set
   always_comb begin
      onehot = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (en && (idx == SELW'(i))) onehot[i] = 1'b1;
      end
   end

endmodule

// File: rtl/bus_transfer_ctrl.sv
// Initiator for the shared 8-bit register bus: sequences one src->dst
// register move per accepted request (DRIVE, CAPTURE, RELEASE) and rejects
// illegal requests with a one-cycle err pulse.
// Optional feature macro: UL8_BUS_IMM_EN (src index NUM_REGS drives req_imm
// onto the bus from the controller instead of a register).
module bus_transfer_ctrl
   import ul8_bus_pkg::*;
#(
   parameter  int NUM_REGS = 4,
   localparam int SELW     = sel_width(NUM_REGS)
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [SELW-1:0]     req_src,
   input  logic [SELW-1:0]     req_dst,
`ifdef UL8_BUS_IMM_EN
   input  logic [BUS_W-1:0]    req_imm,
`endif
   output logic [NUM_REGS-1:0] reg_write,
   output logic [NUM_REGS-1:0] reg_load,
   input  logic [BUS_W-1:0]    bus_in,
   output logic [BUS_W-1:0]    bus_out,
   output logic                bus_oe,
   output logic [BUS_W-1:0]    rd_data,
   output logic                done,
   output logic                err
);

   bus_state_e      state;
   logic [SELW-1:0] src_q;
   logic [SELW-1:0] dst_q;
   logic            wr_en_q;
   logic            ld_en_q;
   logic            ready_q;
   logic            done_q;
   logic            err_q;
   logic            req_ok;
   logic            src_is_imm;
`ifdef UL8_BUS_IMM_EN
   logic [BUS_W-1:0] imm_q;
   logic             imm_sel_q;
   logic             oe_q;
   logic [BUS_W-1:0] out_q;
`endif

   // Legality of the presented request: distinct indices, both in range
   // (the immediate code point is only legal as a source)
   always_comb begin
      src_is_imm = 1'b0;
`ifdef UL8_BUS_IMM_EN
      src_is_imm = (int'(req_src) == NUM_REGS);
`endif
      req_ok = (req_src != req_dst) &&
               (int'(req_dst) < NUM_REGS) &&
               ((int'(req_src) < NUM_REGS) || src_is_imm);
   end

   // Transfer sequencer; every output is registered so strobes depend only
   // on state and latched indices, and reset clears them asynchronously
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= ST_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         wr_en_q <= 1'b0;
         ld_en_q <= 1'b0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rd_data <= '0;
`ifdef UL8_BUS_IMM_EN
         imm_q     <= '0;
         imm_sel_q <= 1'b0;
         oe_q      <= 1'b0;
         out_q     <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  src_q   <= req_src;
                  dst_q   <= req_dst;
                  ready_q <= 1'b0;
`ifdef UL8_BUS_IMM_EN
                  imm_q     <= req_imm;
                  imm_sel_q <= src_is_imm;
`endif
                  if (!req_ok) begin
                     state <= ST_ERROR;
                     err_q <= 1'b1;
                  end else begin
                     state <= ST_DRIVE;
`ifdef UL8_BUS_IMM_EN
                     wr_en_q <= !src_is_imm;
                     oe_q    <= src_is_imm;
                     out_q   <= src_is_imm ? req_imm : '0;
`else
                     wr_en_q <= 1'b1;
`endif
                  end
               end
            end
            ST_DRIVE: begin
               state   <= ST_CAPTURE;
               ld_en_q <= 1'b1;
            end
            ST_CAPTURE: begin
               state   <= ST_RELEASE;
               wr_en_q <= 1'b0;
               ld_en_q <= 1'b0;
               done_q  <= 1'b1;
`ifdef UL8_BUS_IMM_EN
               oe_q    <= 1'b0;
               out_q   <= '0;
               rd_data <= imm_sel_q ? imm_q : bus_in;
`else
               rd_data <= bus_in;
`endif
            end
            ST_RELEASE: begin
               state   <= ST_IDLE;
               ready_q <= 1'b1;
            end
            ST_ERROR: begin
               state   <= ST_IDLE;
               ready_q <= 1'b1;
            end
            default: begin
               state   <= ST_IDLE;
               ready_q <= 1'b1;
               wr_en_q <= 1'b0;
               ld_en_q <= 1'b0;
`ifdef UL8_BUS_IMM_EN
               oe_q    <= 1'b0;
               out_q   <= '0;
`endif
            end
         endcase
      end
   end

   assign req_ready = ready_q;
   assign done      = done_q;
   assign err       = err_q;

`ifdef UL8_BUS_IMM_EN
   assign bus_oe  = oe_q;
   assign bus_out = out_q;
`else
   assign bus_oe  = 1'b0;
   assign bus_out = '0;
`endif

   bus_sel_decoder #(
      .NUM_REGS (NUM_REGS),
      .SELW     (SELW)
   ) u_write_dec (
      .idx    (src_q),
      .en     (wr_en_q),
      .onehot (reg_write)
   );

   bus_sel_decoder #(
      .NUM_REGS (NUM_REGS),
      .SELW     (SELW)
   ) u_load_dec (
      .idx    (dst_q),
      .en     (ld_en_q),
      .onehot (reg_load)
   );

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Bench for bus_transfer_ctrl with a behavioural register bank on the bus.
module tb_bus_transfer_ctrl;
   import ul8_bus_pkg::*;

   localparam int NUM_REGS = 5;
   localparam int SELW     = sel_width(NUM_REGS);
   localparam int IW       = $clog2(NUM_REGS);
`ifdef UL8_BUS_IMM_EN
   localparam int IMM_N = 1;
`else
   localparam int IMM_N = 0;
`endif

   logic                clk       = 1'b0;
   logic                resetn    = 1'b1;
   logic                req_valid = 1'b0;
   logic                req_ready;
   logic [SELW-1:0]     req_src   = '0;
   logic [SELW-1:0]     req_dst   = '0;
`ifdef UL8_BUS_IMM_EN
   logic [7:0]          req_imm   = '0;
`endif
   logic [NUM_REGS-1:0] reg_write;
   logic [NUM_REGS-1:0] reg_load;
   logic [7:0]          bus_in;
   logic [7:0]          bus_out;
   logic                bus_oe;
   logic [7:0]          rd_data;
   logic                done;
   logic                err;

   always #5 clk = ~clk;

   bus_transfer_ctrl #(.NUM_REGS(NUM_REGS)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_src   (req_src),
      .req_dst   (req_dst),
`ifdef UL8_BUS_IMM_EN
      .req_imm   (req_imm),
`endif
      .reg_write (reg_write),
      .reg_load  (reg_load),
      .bus_in    (bus_in),
      .bus_out   (bus_out),
      .bus_oe    (bus_oe),
      .rd_data   (rd_data),
      .done      (done),
      .err       (err)
   );

   // Register bank: write strobe enables the output from the next edge,
   // load strobe captures the bus at the edge
   logic [7:0]          bank [NUM_REGS];
   logic [NUM_REGS-1:0] drv_q;
   logic                pre_en  = 1'b0;
   logic [IW-1:0]       pre_idx = '0;
   logic [7:0]          pre_val = '0;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         drv_q <= '0;
      end else begin
         drv_q <= reg_write;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_load[i]) bank[i] <= bus_in;
         end
         if (pre_en) bank[pre_idx] <= pre_val;
      end
   end

   always_comb begin
      bus_in = 8'h00;
      if (bus_oe) bus_in = bus_out;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (drv_q[i]) bus_in = bank[i];
      end
   end

   // Reference state: expected bank contents and last sampled byte
   logic [7:0] mbank [NUM_REGS];
   logic [7:0] m_rd = 8'h00;
   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_acc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      chk("inv:wr_onehot0", 32'($onehot0(reg_write)), 1);
      chk("inv:ld_onehot0", 32'($onehot0(reg_load)), 1);
      chk("inv:wr_and_ld", 32'(|(reg_write & reg_load)), 0);
      chk("inv:oe_and_wr", 32'(bus_oe && (|reg_write)), 0);
`ifndef UL8_BUS_IMM_EN
      chk("inv:no_ctrl_drive", {23'd0, bus_oe, bus_out}, 0);
`endif
   endtask

   task automatic preload(input int idx, input logic [7:0] val);
      pre_idx = IW'(idx);
      pre_val = val;
      pre_en  = 1'b1;
      tick();
      pre_en  = 1'b0;
      mbank[idx] = val;
   endtask

   task automatic do_xfer(input int src, input int dst, input logic [7:0] imm,
                          input bit chain, input int nsrc, input int ndst, input string tag);
      bit got, legal, is_imm;
      logic [7:0] val;
      int k_done, k_err, k_rdy, n_done, n_err, n_wr, n_ld, n_oe;
      logic [NUM_REGS-1:0] wr_or, ld_or;
      req_src = SELW'(src);
      req_dst = SELW'(dst);
`ifdef UL8_BUS_IMM_EN
      req_imm = imm;
`endif
      req_valid = 1'b1;
      got = 1'b0;
      for (int w = 0; w < 20; w++) begin
         got = (req_ready === 1'b1);
         tick();
         if (got) break;
      end
      chk({tag, ":accept"}, 32'(got), 1);
      if (!got) begin
         req_valid = 1'b0;
         return;
      end
      last_acc = cyc;
      if (chain) begin
         req_src = SELW'(nsrc);
         req_dst = SELW'(ndst);
      end else begin
         req_valid = 1'b0;
      end
      k_done = -1; k_err = -1; k_rdy = -1;
      n_done = 0; n_err = 0; n_wr = 0; n_ld = 0; n_oe = 0;
      wr_or = '0; ld_or = '0;
      for (int k = 0; k < 10; k++) begin
         if (done) begin n_done++; if (k_done < 0) k_done = k; end
         if (err)  begin n_err++;  if (k_err < 0)  k_err = k;  end
         if (|reg_write) n_wr++;
         if (|reg_load)  n_ld++;
         if (bus_oe)     n_oe++;
         wr_or = wr_or | reg_write;
         ld_or = ld_or | reg_load;
         if (req_ready) begin k_rdy = k; break; end
         tick();
      end
      is_imm = (IMM_N == 1) && (src == NUM_REGS);
      legal  = (src != dst) && (dst < NUM_REGS) && ((src < NUM_REGS) || is_imm);
      if (legal) begin
         val = is_imm ? imm : mbank[src];
         chk({tag, ":done_at"},  k_done, 2);
         chk({tag, ":n_done"},   n_done, 1);
         chk({tag, ":n_err"},    n_err, 0);
         chk({tag, ":ready_at"}, k_rdy, 3);
         chk({tag, ":n_wr"},     n_wr, is_imm ? 0 : 2);
         chk({tag, ":wr_bits"},  32'(wr_or), is_imm ? 0 : 32'(NUM_REGS'(1) << src));
         chk({tag, ":n_ld"},     n_ld, 1);
         chk({tag, ":ld_bits"},  32'(ld_or), 32'(NUM_REGS'(1) << dst));
         chk({tag, ":n_oe"},     n_oe, is_imm ? 2 : 0);
         mbank[dst] = val;
         m_rd = val;
      end else begin
         chk({tag, ":err_at"},   k_err, 0);
         chk({tag, ":n_err"},    n_err, 1);
         chk({tag, ":n_done"},   n_done, 0);
         chk({tag, ":ready_at"}, k_rdy, 1);
         chk({tag, ":n_wr"},     n_wr, 0);
         chk({tag, ":n_ld"},     n_ld, 0);
         chk({tag, ":n_oe"},     n_oe, 0);
      end
      chk({tag, ":rd_data"}, 32'(rd_data), 32'(m_rd));
      for (int i = 0; i < NUM_REGS; i++) begin
         chk({tag, ":bank"}, 32'(bank[i]), 32'(mbank[i]));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a1, s, d;
      #2;
      resetn = 1'b0;
      tick();
      tick();
      chk("reset:reg_write", 32'(reg_write), 0);
      chk("reset:reg_load",  32'(reg_load), 0);
      chk("reset:rd_data",   32'(rd_data), 0);
      chk("reset:done",      32'(done), 0);
      chk("reset:err",       32'(err), 0);
      chk("reset:bus_oe",    32'(bus_oe), 0);
      chk("reset:bus_out",   32'(bus_out), 0);
      resetn = 1'b1;
      tick();
      chk("reset:ready_after_release", 32'(req_ready), 1);

      for (int i = 0; i < NUM_REGS; i++) preload(i, 8'(8'h10 + i));

      // Basic move r1 -> r2
      preload(1, 8'hA5);
      do_xfer(1, 2, 8'h00, 1'b0, 0, 0, "t1_r1_to_r2");
      chk("t1:r2_value", 32'(bank[2]), 32'h A5);

      // Rejections: same index, source out of range, destination out of range
      do_xfer(3, 3, 8'h00, 1'b0, 0, 0, "t2_same_idx");
      do_xfer(NUM_REGS + 1, 1, 8'h00, 1'b0, 0, 0, "t3_src_range");
      do_xfer(0, NUM_REGS, 8'h00, 1'b0, 0, 0, "t3_dst_range");
`ifndef UL8_BUS_IMM_EN
      do_xfer(NUM_REGS, 0, 8'h00, 1'b0, 0, 0, "t3_src_eq_n");
`endif

      // Reset in the middle of CAPTURE
      preload(0, 8'h11);
      preload(4, 8'h22);
      req_src = SELW'(0);
      req_dst = SELW'(4);
      req_valid = 1'b1;
      chk("t4:ready_before", 32'(req_ready), 1);
      tick();
      req_valid = 1'b0;
      tick();
      chk("t4:load_in_capture", 32'(reg_load), 32'(NUM_REGS'(1) << 4));
      resetn = 1'b0;
      #1;
      chk("t4:wr_drop", 32'(reg_write), 0);
      chk("t4:ld_drop", 32'(reg_load), 0);
      chk("t4:rd_clear", 32'(rd_data), 0);
      chk("t4:done_low", 32'(done), 0);
      m_rd = 8'h00;
      tick();
      tick();
      resetn = 1'b1;
      tick();
      chk("t4:ready_after", 32'(req_ready), 1);
      chk("t4:r4_kept", 32'(bank[4]), 32'(mbank[4]));
      chk("t4:rd_after", 32'(rd_data), 0);

      // Back-to-back with valid held: r0 -> r1 then r1 -> r2
      preload(0, 8'h3C);
      do_xfer(0, 1, 8'h00, 1'b1, 1, 2, "t5_a");
      a1 = last_acc;
      do_xfer(1, 2, 8'h00, 1'b0, 0, 0, "t5_b");
      chk("t5:accept_gap", last_acc - a1, 4);
      chk("t5:r2_value", 32'(bank[2]), 32'h3C);

`ifdef UL8_BUS_IMM_EN
      do_xfer(NUM_REGS, 0, 8'h7E, 1'b0, 0, 0, "t6_imm");
      chk("t6:r0_value", 32'(bank[0]), 32'h7E);
      chk("t6:rd_value", 32'(rd_data), 32'h7E);
`endif

      // Randomized requests, mostly legal, some out of range or colliding
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 4) == 0) preload($urandom_range(0, NUM_REGS - 1), 8'($urandom));
         if ($urandom_range(0, 3) == 0) s = $urandom_range(0, (1 << SELW) - 1);
         else                           s = $urandom_range(0, NUM_REGS - 1 + IMM_N);
         if ($urandom_range(0, 3) == 0) d = $urandom_range(0, (1 << SELW) - 1);
         else                           d = $urandom_range(0, NUM_REGS - 1);
         do_xfer(s, d, 8'($urandom), 1'b0, 0, 0, "rnd");
         if ($urandom_range(0, 1) == 1) tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
